// File: rtl/nl_lut_loader_pkg.sv
// Shared types and LUT layout constants for the nonlinear activation block and its loader.
// The activation block indexes its LUT with the same constants, so both sides agree on the entry order.
package nl_lut_loader_pkg;

    localparam int LUT_SIZE    = 58;
    localparam int LUT_ADDR    = 6;
    localparam int DATA_WIDTH  = 8;
    localparam int N_DIM_ARRAY = 4;
    localparam int ADDR_SIZE   = 14;

    localparam int SHIFT_ADDRESS_SIG  = 0;
    localparam int X_MIN_SIG          = 1;
    localparam int X_MAX_SIG          = 2;
    localparam int Y_MIN_SIG          = 3;
    localparam int Y_MAX_SIG          = 4;
    localparam int SHIFT_ADDRESS_TANH = 5;
    localparam int X_MIN_TANH         = 6;
    localparam int X_MAX_TANH         = 7;
    localparam int Y_MIN_TANH         = 8;
    localparam int Y_MAX_TANH         = 9;
    localparam int X_PWS_SIG_BASE     = 10;
    localparam int A_SIG_BASE         = 18;
    localparam int B_SIG_BASE         = 26;
    localparam int X_PWS_TANH_BASE    = 34;
    localparam int A_TANH_BASE        = 42;
    localparam int B_TANH_BASE        = 50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_UNPACK,
        ST_DONE
    } ld_state_e;

    // Lane-index width; a single-lane word still needs a 1-bit index.
    function automatic int bidx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/nl_word_unpacker.sv
// Holds one config word and presents the lane picked by byte_idx_i (lane 0 = bits DW-1:0).
// Word loads one cycle after load_i is sampled; lane select is combinational, no backpressure.
module nl_word_unpacker #(
    parameter int DATA_WIDTH  = 8,
    parameter int N_DIM_ARRAY = 4,
    parameter int BIDX_W      = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              load_i,
    input  logic [N_DIM_ARRAY*DATA_WIDTH-1:0] word_i,
    input  logic [BIDX_W-1:0]                 byte_idx_i,
    output logic [DATA_WIDTH-1:0]             lane_o
);

    logic [N_DIM_ARRAY-1:0][DATA_WIDTH-1:0] word_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= word_i;
        end
    end

    assign lane_o = word_q[byte_idx_i];

endmodule

// File: rtl/nl_lut_loader.sv
// Fetches packed LUT bytes from config memory and writes them one per cycle into the activation LUT.
// Writes are registered (1-cycle latency); lut_lock_i stalls unpacking, abort_i returns to IDLE at once.
module nl_lut_loader
    import nl_lut_loader_pkg::*;
#(
    parameter int P_LUT_ADDR    = LUT_ADDR,
    parameter int P_DATA_WIDTH  = DATA_WIDTH,
    parameter int P_N_DIM_ARRAY = N_DIM_ARRAY,
    parameter int P_ADDR_SIZE   = ADDR_SIZE
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  start_i,
    input  logic [P_ADDR_SIZE-1:0]                start_addr_i,
    input  logic [P_LUT_ADDR:0]                   num_entries_i,
    input  logic                                  abort_i,
    input  logic                                  lut_lock_i,
    output logic                                  cfg_rd_en_o,
    output logic [P_ADDR_SIZE-1:0]                cfg_rd_addr_o,
    input  logic [P_N_DIM_ARRAY*P_DATA_WIDTH-1:0] cfg_rd_data_i,
    output logic                                  wr_en_ext_lut_o,
    output logic [P_LUT_ADDR-1:0]                 wr_addr_ext_lut_o,
    output logic [P_DATA_WIDTH-1:0]               wr_data_ext_lut_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  error_o
);

    localparam int BIDX_W = bidx_width(P_N_DIM_ARRAY);
    localparam logic [P_LUT_ADDR:0]   LUT_SIZE_W = (P_LUT_ADDR+1)'(LUT_SIZE);
    localparam logic [BIDX_W-1:0]     LAST_LANE  = BIDX_W'(P_N_DIM_ARRAY-1);

    ld_state_e                   state_q, state_d;
    logic [P_ADDR_SIZE-1:0]      addr_q, addr_d;
    logic [P_LUT_ADDR:0]         num_q, num_d;
    logic [P_LUT_ADDR-1:0]       cnt_q, cnt_d;
    logic [BIDX_W-1:0]           bidx_q, bidx_d;
    logic                        wr_en_q, wr_en_d;
    logic [P_LUT_ADDR-1:0]       wr_addr_q, wr_addr_d;
    logic [P_DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;
    logic [P_DATA_WIDTH-1:0]     lane_dat;
    logic                        last_entry;
    logic                        last_lane;

    nl_word_unpacker #(
        .DATA_WIDTH  (P_DATA_WIDTH),
        .N_DIM_ARRAY (P_N_DIM_ARRAY),
        .BIDX_W      (BIDX_W)
    ) u_unpacker (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (state_q == ST_WAIT),
        .word_i     (cfg_rd_data_i),
        .byte_idx_i (bidx_q),
        .lane_o     (lane_dat)
    );

    // The counter stops at num-1, so a write address never reaches LUT_SIZE.
    assign last_entry = ({1'b0, cnt_q} == (num_q - (P_LUT_ADDR+1)'(1)));
    assign last_lane  = (bidx_q == LAST_LANE);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        num_d     = num_q;
        cnt_d     = cnt_q;
        bidx_d    = bidx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = err_q;

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (num_entries_i > LUT_SIZE_W) begin
                            err_d = 1'b1;
                        end else begin
                            err_d   = 1'b0;
                            addr_d  = start_addr_i;
                            num_d   = num_entries_i;
                            cnt_d   = '0;
                            bidx_d  = '0;
                            state_d = (num_entries_i == '0) ? ST_DONE : ST_FETCH;
                        end
                    end
                end
                ST_FETCH:  state_d = ST_WAIT;
                ST_WAIT:   state_d = ST_UNPACK;
                ST_UNPACK: begin
                    if (!lut_lock_i) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q;
                        wr_data_d = lane_dat;
                        if (last_entry) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d  = cnt_q + P_LUT_ADDR'(1);
                            bidx_d = last_lane ? '0 : bidx_q + BIDX_W'(1);
                            if (last_lane) begin
                                addr_d  = addr_q + P_ADDR_SIZE'(1);
                                state_d = ST_FETCH;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
            bidx_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
            bidx_q    <= bidx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cfg_rd_en_o       = (state_q == ST_FETCH);
    assign cfg_rd_addr_o     = (state_q == ST_FETCH) ? addr_q : '0;
    assign busy_o            = (state_q != ST_IDLE);
    assign done_o            = done_q;
    assign error_o           = err_q;
    assign wr_en_ext_lut_o   = wr_en_q;
    assign wr_addr_ext_lut_o = wr_addr_q;
    assign wr_data_ext_lut_o = wr_data_q;

endmodule
